line_fill_responder: RTL and testbench



---
 rtl/line_fill_responder_if.sv | 26 ++
 rtl/line_fill_responder.sv | 178 +++++++++++++++++
 tb/tb_line_fill_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_responder_if.sv
// Line-fill bus between a cache (master) and the memory-side responder (slave).
// Carries the miss request, the beat stream back to the cache and the preload port.
interface line_fill_responder_if;
  logic        miss;
  logic [31:0] cpu_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid;
  logic        mem_last;
  logic        busy;
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;
  logic        pre_err;

  modport master (
    output miss, cpu_addr, pre_we, pre_addr, pre_data,
    input  mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last, busy, pre_err
  );

  modport slave (
    input  miss, cpu_addr, pre_we, pre_addr, pre_data,
    output mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last, busy, pre_err
  );
endinterface

// File: rtl/line_fill_responder.sv
// Memory-side line-fill responder: on a miss rising edge it streams one aligned
// line as LINE_WORDS beats out of an internal word array. The array is loaded
// through a preload port that is only honoured while the responder is idle.
module line_fill_responder #(
  parameter int LINE_WORDS = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int FIRST_LAT  = 4,
  parameter int BEAT_GAP   = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  line_fill_responder_if.slave bus
);

  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int CNT_W = 16;
  localparam logic [4:0]       LAST_K  = 5'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] LAT_END = CNT_W'(FIRST_LAT - 2);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(BEAT_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LAT   = 3'd1,
    BEAT  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [24:0]      base;        // line base address bits [31:7]
  logic [24:0]      base_next;
  logic [4:0]       k;           // beat index within the line
  logic [4:0]       k_next;
  logic [CNT_W-1:0] cnt;         // shared latency / gap counter
  logic [CNT_W-1:0] cnt_next;
  logic             miss_prev;
  logic             miss_rise;
  logic             valid;
  logic             last;
  logic             busy;
  logic             pre_err;
  logic [31:0]      data;
  logic [31:0]      mem [MEM_DEPTH];
  logic [29:0]      rd_word;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             unused_bits;

  // miss_prev comes out of reset high so a miss already high at release is not an edge.
  assign miss_rise = bus.miss & ~miss_prev;

  // Word address of the beat being fetched; line alignment keeps k from carrying into base.
  assign rd_word = {base, k};
  assign rd_idx  = rd_word[AW-1:0];
  assign wr_idx  = bus.pre_addr[AW+1:2];

  assign unused_bits = ^{bus.pre_addr[31:AW+2], bus.pre_addr[1:0], rd_word[29:AW]};

  assign bus.mem_addr       = (state == IDLE) ? bus.cpu_addr : {base, k, 2'b00};
  assign bus.mem_data_in    = data;
  assign bus.mem_wstb       = 4'b1111;
  assign bus.mem_data_valid = valid;
  assign bus.mem_last       = last;
  assign bus.busy           = busy;
  assign bus.pre_err        = pre_err;

  // Next-state logic for the fill sequencer; a low miss abandons any active fill.
  always_comb begin
    state_next = state;
    base_next  = base;
    k_next     = k;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (miss_rise) begin
          state_next = LAT;
          base_next  = bus.cpu_addr[31:7];
          k_next     = 5'd0;
          cnt_next   = {CNT_W{1'b0}};
        end else begin
          state_next = IDLE;
        end
      end
      LAT: begin
        if (!bus.miss) begin
          state_next = IDLE;
        end else if (cnt == LAT_END) begin
          state_next = BEAT;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      BEAT: begin
        if (!bus.miss) begin
          state_next = IDLE;
        end else if (k == LAST_K) begin
          state_next = DRAIN;
        end else begin
          state_next = GAP;
          k_next     = k + 5'd1;
          cnt_next   = {CNT_W{1'b0}};
        end
      end
      GAP: begin
        if (!bus.miss) begin
          state_next = IDLE;
        end else if (cnt == GAP_END) begin
          state_next = BEAT;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      DRAIN: begin
        if (!bus.miss) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state, line base, beat and wait counters, and miss edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      base      <= 25'd0;
      k         <= 5'd0;
      cnt       <= {CNT_W{1'b0}};
      miss_prev <= 1'b1;
    end else begin
      state     <= state_next;
      base      <= base_next;
      k         <= k_next;
      cnt       <= cnt_next;
      miss_prev <= bus.miss;
    end
  end

  // Registered beat outputs; data is fetched only on the edge that enters a beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      last  <= 1'b0;
      busy  <= 1'b0;
      data  <= 32'd0;
    end else begin
      valid <= (state_next == BEAT);
      last  <= (state_next == BEAT) && (k_next == LAST_K);
      busy  <= (state_next != IDLE);
      if (state_next == BEAT) begin
        data <= mem[rd_idx];
      end
    end
  end

  // Sticky flag for preload attempts made while a fill is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_err <= 1'b0;
    end else if (bus.pre_we && (state != IDLE)) begin
      pre_err <= 1'b1;
    end
  end

  // Backing array: preload writes land only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.pre_we && (state == IDLE)) begin
      mem[wr_idx] <= bus.pre_data;
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: two instances (default timing and a slow
// FIRST_LAT=2/BEAT_GAP=3 variant) share one stimulus stream and are compared
// every cycle against a timeline model of the fill, plus literal spot values.
module tb_line_fill_responder;

  localparam int FL_A  = 4;
  localparam int BG_A  = 1;
  localparam int FL_B  = 2;
  localparam int BG_B  = 3;
  localparam int DEPTH = 4096;
  localparam int LINE  = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = 32'd0;
  logic [31:0] pre_data = 32'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  line_fill_responder_if bus_a ();
  line_fill_responder_if bus_b ();

  assign bus_a.miss     = miss;
  assign bus_a.cpu_addr = cpu_addr;
  assign bus_a.pre_we   = pre_we;
  assign bus_a.pre_addr = pre_addr;
  assign bus_a.pre_data = pre_data;
  assign bus_b.miss     = miss;
  assign bus_b.cpu_addr = cpu_addr;
  assign bus_b.pre_we   = pre_we;
  assign bus_b.pre_addr = pre_addr;
  assign bus_b.pre_data = pre_data;

  line_fill_responder #(.LINE_WORDS(LINE), .MEM_DEPTH(DEPTH), .FIRST_LAT(FL_A), .BEAT_GAP(BG_A))
    u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  line_fill_responder #(.LINE_WORDS(LINE), .MEM_DEPTH(DEPTH), .FIRST_LAT(FL_B), .BEAT_GAP(BG_B))
    u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];
  bit          active = 1'b0;
  bit          miss_prev_m = 1'b1;
  bit          perr_m = 1'b0;
  int          j = 0;                 // edges since the fill started
  logic [31:0] base_m = 32'd0;
  logic [31:0] data_a_m = 32'd0;
  logic [31:0] data_b_m = 32'd0;

  function automatic int idx_of(input logic [31:0] byte_addr);
    return int'((byte_addr >> 2) % 32'(DEPTH));
  endfunction

  // Outputs a fill with timing (fl, bg) must show jj edges after the start edge.
  function automatic void expect_out(input int fl, input int bg, input bit act, input int jj,
                                     input logic [31:0] base, input logic [31:0] cpu,
                                     output bit v, output bit l, output logic [31:0] a,
                                     output int m_out);
    int d;
    int m;
    int r;
    v = 1'b0;
    l = 1'b0;
    a = cpu;
    m_out = -1;
    if (act) begin
      if (jj < fl - 1) begin
        a = base;
      end else begin
        d = jj - (fl - 1);
        m = d / (bg + 1);
        r = d % (bg + 1);
        if (m > LINE - 1 || (m == LINE - 1 && r != 0)) begin
          a = base + 32'(4 * (LINE - 1));
        end else if (r == 0) begin
          v = 1'b1;
          l = (m == LINE - 1);
          a = base + 32'(4 * m);
          m_out = m;
        end else begin
          a = base + 32'(4 * (m + 1));
        end
      end
    end
  endfunction

  // Model update on every clock edge and on asynchronous reset.
  initial begin
    bit v;
    bit l;
    logic [31:0] a;
    int m;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        active = 1'b0;
        miss_prev_m = 1'b1;
        perr_m = 1'b0;
        data_a_m = 32'd0;
        data_b_m = 32'd0;
        j = 0;
      end else begin
        if (pre_we) begin
          if (active) perr_m = 1'b1;
          else mem_m[idx_of(pre_addr)] = pre_data;
        end
        if (!active) begin
          if (miss && !miss_prev_m) begin
            active = 1'b1;
            j = 0;
            base_m = {cpu_addr[31:7], 7'b0};
          end
        end else if (!miss) begin
          active = 1'b0;
        end else begin
          j++;
        end
        miss_prev_m = miss;
        expect_out(FL_A, BG_A, active, j, base_m, cpu_addr, v, l, a, m);
        if (v) data_a_m = mem_m[idx_of(base_m + 32'(4 * m))];
        expect_out(FL_B, BG_B, active, j, base_m, cpu_addr, v, l, a, m);
        if (v) data_b_m = mem_m[idx_of(base_m + 32'(4 * m))];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial begin
    bit v;
    bit l;
    logic [31:0] a;
    int m;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        expect_out(FL_A, BG_A, active, j, base_m, cpu_addr, v, l, a, m);
        check("a_valid", 32'(bus_a.mem_data_valid), 32'(v));
        check("a_last", 32'(bus_a.mem_last), 32'(l));
        check("a_addr", bus_a.mem_addr, a);
        check("a_data", bus_a.mem_data_in, data_a_m);
        check("a_busy", 32'(bus_a.busy), 32'(active));
        check("a_perr", 32'(bus_a.pre_err), 32'(perr_m));
        check("a_wstb", 32'(bus_a.mem_wstb), 32'hF);
        expect_out(FL_B, BG_B, active, j, base_m, cpu_addr, v, l, a, m);
        check("b_valid", 32'(bus_b.mem_data_valid), 32'(v));
        check("b_last", 32'(bus_b.mem_last), 32'(l));
        check("b_addr", bus_b.mem_addr, a);
        check("b_data", bus_b.mem_data_in, data_b_m);
        check("b_busy", 32'(bus_b.busy), 32'(active));
        check("b_perr", 32'(bus_b.pre_err), 32'(perr_m));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_valid"}, 32'(bus_a.mem_data_valid), 32'd0);
    check({tag, "_a_last"}, 32'(bus_a.mem_last), 32'd0);
    check({tag, "_a_busy"}, 32'(bus_a.busy), 32'd0);
    check({tag, "_a_data"}, bus_a.mem_data_in, 32'd0);
    check({tag, "_a_perr"}, 32'(bus_a.pre_err), 32'd0);
    check({tag, "_b_valid"}, 32'(bus_b.mem_data_valid), 32'd0);
    check({tag, "_b_busy"}, 32'(bus_b.busy), 32'd0);
    check({tag, "_b_data"}, bus_b.mem_data_in, 32'd0);
  endtask

  // Hand-computed values at chosen cycles of each directed fill.
  task automatic lit_check(input int scen, input int jj);
    case (scen)
      1: begin
        if (jj == 1) check("s1_b_beat0_data", bus_b.mem_data_in, 32'h0000_1000);
        if (jj == 2) check("s1_a_pre_valid", 32'(bus_a.mem_data_valid), 32'd0);
        if (jj == 3) check("s1_a_beat0_addr", bus_a.mem_addr, 32'h0000_0400);
        if (jj == 3) check("s1_a_beat0_data", bus_a.mem_data_in, 32'h0000_1000);
        if (jj == 4) check("s1_a_gap_addr", bus_a.mem_addr, 32'h0000_0404);
        if (jj == 4) check("s1_a_gap_data", bus_a.mem_data_in, 32'h0000_1000);
        if (jj == 5) check("s1_a_beat1_data", bus_a.mem_data_in, 32'h0000_1001);
        if (jj == 5) check("s1_b_beat1_valid", 32'(bus_b.mem_data_valid), 32'd1);
        if (jj == 9) check("s1_perr_before", 32'(bus_a.pre_err), 32'd0);
        if (jj == 12) check("s1_perr_after", 32'(bus_a.pre_err), 32'd1);
        if (jj == 63) check("s1_a_last_early", 32'(bus_a.mem_last), 32'd0);
        if (jj == 65) check("s1_a_last", 32'(bus_a.mem_last), 32'd1);
        if (jj == 65) check("s1_a_beat31_addr", bus_a.mem_addr, 32'h0000_047C);
        if (jj == 65) check("s1_a_beat31_data", bus_a.mem_data_in, 32'h0000_101F);
        if (jj == 125) check("s1_b_last", 32'(bus_b.mem_last), 32'd1);
        if (jj == 125) check("s1_b_beat31_data", bus_b.mem_data_in, 32'h0000_101F);
        if (jj == 128) check("s1_a_drain_addr", bus_a.mem_addr, 32'h0000_047C);
      end
      2: begin
        if (jj == 1) check("s2_b_beat0_data", bus_b.mem_data_in, 32'hCAFE_0001);
        if (jj == 2) check("s2_perr_sticky", 32'(bus_b.pre_err), 32'd1);
        if (jj == 3) check("s2_a_beat0_data", bus_a.mem_data_in, 32'hCAFE_0001);
        if (jj == 5) check("s2_a_beat1_old", bus_a.mem_data_in, 32'h0000_1001);
        if (jj == 13) check("s2_a_beat5_addr", bus_a.mem_addr, 32'h0000_0414);
        if (jj == 13) check("s2_a_beat5_data", bus_a.mem_data_in, 32'h0000_1005);
      end
      4: begin
        if (jj == 0) check("s4_a_lat_addr", bus_a.mem_addr, 32'hFFFF_FF80);
        if (jj == 3) check("s4_a_beat0_data", bus_a.mem_data_in, 32'h0FE0_0FE0);
        if (jj == 65) check("s4_a_beat31_addr", bus_a.mem_addr, 32'hFFFF_FFFC);
        if (jj == 65) check("s4_a_beat31_data", bus_a.mem_data_in, 32'h0FFF_0FFF);
        if (jj == 66) check("s4_a_drain_addr", bus_a.mem_addr, 32'hFFFF_FFFC);
      end
      default: begin
      end
    endcase
  endtask

  // One fill: miss rises with addr, stays high through cycle `hold`, then drops.
  task automatic fill(input logic [31:0] addr, input int hold, input int scen, input bit pre_at_rise);
    if (pre_at_rise) begin
      pre_we = 1'b1;
      pre_addr = 32'h0000_0400;
      pre_data = 32'hCAFE_0001;
    end
    cpu_addr = addr;
    miss = 1'b1;
    tick();
    for (int jj = 0; jj <= hold; jj++) begin
      pre_we = 1'b0;
      if (scen == 1 && jj == 10) begin
        pre_we = 1'b1;
        pre_addr = 32'h0000_0404;
        pre_data = 32'hDEAD_BEEF;
      end
      if (jj == hold) miss = 1'b0;
      @(negedge clk);
      lit_check(scen, jj);
      tick();
    end
    pre_we = 1'b0;
    @(negedge clk);
    check("post_busy", 32'(bus_a.busy), 32'd0);
    check("post_addr_tracks", bus_a.mem_addr, addr);
    check("post_valid", 32'(bus_b.mem_data_valid), 32'd0);
    if (scen == 2) check("s2_data_holds", bus_a.mem_data_in, 32'h0000_1005);
  endtask

  initial begin
    logic [31:0] tmp;
    int r;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    check("rst_wstb", 32'(bus_a.mem_wstb), 32'hF);
    tick();
    reset_n = 1'b1;
    tick();

    // Preload the whole array (random upper/lower address bits must be ignored)
    pre_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tmp = $urandom;
      pre_addr = (tmp & 32'hFFFF_C003) | (32'(i) << 2);
      pre_data = $urandom;
      tick();
    end
    for (int i = 0; i < LINE; i++) begin
      tmp = $urandom;
      pre_addr = (tmp & 32'hFFFF_C000) | (32'h0000_0400 + 32'(4 * i));
      pre_data = 32'h0000_1000 + 32'(i);
      tick();
    end
    pre_addr = 32'h0000_3F80;
    pre_data = 32'h0FE0_0FE0;
    tick();
    pre_addr = 32'h0000_3FFC;
    pre_data = 32'h0FFF_0FFF;
    tick();
    pre_we = 1'b0;
    tick();

    // Full fill, rejected preload during the fill
    fill(32'h0000_0408, 130, 1, 1'b0);
    tick();
    // Preload at the miss rise, abort after beat 5 of the default instance
    fill(32'h0000_0408, 13, 2, 1'b1);
    tick();

    // Reset during beat 12 of the default instance
    cpu_addr = 32'h0000_0408;
    miss = 1'b1;
    tick();
    repeat (27) tick();
    @(negedge clk);
    check("s3_a_beat12_valid", 32'(bus_a.mem_data_valid), 32'd1);
    check("s3_a_beat12_addr", bus_a.mem_addr, 32'h0000_0430);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("s3rst");
    tick();
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("s3_no_restart_busy", 32'(bus_a.busy), 32'd0);
      check("s3_no_restart_valid", 32'(bus_b.mem_data_valid), 32'd0);
      tick();
    end
    miss = 1'b0;
    tick();

    // Wrap at the top of the address space
    fill(32'hFFFF_FF80, 70, 4, 1'b0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 999));
      if (!miss && r < 60) miss = 1'b1;
      else if (miss && r < 6) miss = 1'b0;
      if ($urandom_range(0, 3) == 0) cpu_addr = $urandom;
      pre_we = ($urandom_range(0, 15) == 0);
      pre_addr = $urandom;
      pre_data = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        #2;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
      tick();
    end
    pre_we = 1'b0;
    miss = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
